// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/response channel between the pipeline MEM stage
// and the load/store sequencer.
//   master : drives req_valid/req_we/req_funct3/req_addr/req_wdata,
//            receives req_ready/resp_valid/resp_rdata/resp_err.
//   slave  : the sequencer side of the same signals.
interface mem_access_unit_if #(
    parameter int D_WIDTH = 32
);
    logic               req_valid;
    logic               req_ready;
    logic               req_we;
    logic [2:0]         req_funct3;
    logic [D_WIDTH-1:0] req_addr;
    logic [D_WIDTH-1:0] req_wdata;
    logic               resp_valid;
    logic [D_WIDTH-1:0] resp_rdata;
    logic               resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer in front of a single-port
// word RAM with registered address, unregistered q and no byte enables.
// Sub-word stores are done as read-modify-write; loads are sign/zero extended;
// misaligned or illegal-funct3 requests are answered with resp_err and never
// reach the RAM.
//   clock, reset_n : clock (rising edge), async active-low reset
//   bus            : request/response channel (slave modport)
//   ram_address    : word address, nonzero only while RD/CAP/WR
//   ram_data       : write data, nonzero only in WR
//   ram_wren       : write enable, high only in WR
//   ram_q          : RAM read data, valid the cycle after the address
module mem_access_unit #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    mem_access_unit_if.slave   bus,
    output logic [D_WIDTH-1:0] ram_address,
    output logic [D_WIDTH-1:0] ram_data,
    output logic               ram_wren,
    input  logic [D_WIDTH-1:0] ram_q
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

    // Only the byte-offset and word-address bits are kept; upper address
    // bits are dropped so accesses wrap modulo the RAM size.
    typedef struct packed {
        logic               we;
        logic [2:0]         f3;
        logic [A_WIDTH+1:0] addr;
        logic [D_WIDTH-1:0] wdata;
    } req_t;

    state_t state, state_nxt;
    req_t   cur;

    logic accept, acc_illegal, acc_misalign, acc_err;
    logic [D_WIDTH-1:0] load_ext, merged;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[D_WIDTH-1:A_WIDTH+2];

    assign accept = bus.req_valid & (state == IDLE);

    // Loads allow 0,1,2,4,5; stores allow 0,1,2.
    assign acc_illegal = bus.req_we ? (bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'd3))
                                    : ((bus.req_funct3[1:0] == 2'd3) | (bus.req_funct3 == 3'd6));
    assign acc_misalign = ((bus.req_funct3[1:0] == 2'd1) & bus.req_addr[0]) |
                          ((bus.req_funct3[1:0] == 2'd2) & (bus.req_addr[1:0] != 2'b00));
    assign acc_err = acc_illegal | acc_misalign;

    // Lane selection from the registered byte offset.
    assign sel_b = ram_q[{cur.addr[1:0], 3'b000} +: 8];
    assign sel_h = ram_q[{cur.addr[1], 4'b0000} +: 16];

    always_comb begin
        case (cur.f3)
            3'd0:    load_ext = {{(D_WIDTH-8){sel_b[7]}}, sel_b};
            3'd1:    load_ext = {{(D_WIDTH-16){sel_h[15]}}, sel_h};
            3'd4:    load_ext = {{(D_WIDTH-8){1'b0}}, sel_b};
            3'd5:    load_ext = {{(D_WIDTH-16){1'b0}}, sel_h};
            default: load_ext = ram_q;
        endcase
    end

    always_comb begin
        merged = ram_q;
        if (cur.f3[1:0] == 2'd0)
            merged[{cur.addr[1:0], 3'b000} +: 8] = cur.wdata[7:0];
        else
            merged[{cur.addr[1], 4'b0000} +: 16] = cur.wdata[15:0];
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.req_valid) begin
                if (acc_err)                                     state_nxt = RESP;
                else if (bus.req_we && bus.req_funct3 == 3'd2)   state_nxt = WR;
                else                                             state_nxt = RD;
            end
            RD:      state_nxt = CAP;
            CAP:     state_nxt = cur.we ? WR : RESP;
            WR:      state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        bus.req_ready  = (state == IDLE);
        bus.resp_valid = (state == RESP);
        ram_address    = '0;
        ram_wren       = 1'b0;
        ram_data       = '0;
        if (state == RD || state == CAP || state == WR)
            ram_address = {{(D_WIDTH-A_WIDTH){1'b0}}, cur.addr[A_WIDTH+1:2]};
        if (state == WR) begin
            ram_wren = 1'b1;
            ram_data = cur.wdata;
        end
    end

    // Request capture and response registers. The store data register is
    // reused to hold the RMW-merged word, so WR always writes cur.wdata.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur             <= '0;
            bus.resp_rdata  <= '0;
            bus.resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                cur <= '{we: bus.req_we, f3: bus.req_funct3,
                         addr: bus.req_addr[A_WIDTH+1:0], wdata: bus.req_wdata};
                if (acc_err) begin
                    bus.resp_rdata <= '0;
                    bus.resp_err   <= 1'b1;
                end
            end
            if (state == CAP) begin
                if (cur.we) begin
                    cur.wdata <= merged;
                end else begin
                    bus.resp_rdata <= load_ext;
                    bus.resp_err   <= 1'b0;
                end
            end
            if (state == WR) begin
                bus.resp_rdata <= '0;
                bus.resp_err   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] ram_address, ram_data, ram_q;
    logic        ram_wren;

    mem_access_unit_if #(.D_WIDTH(32)) bus();

    mem_access_unit #(.D_WIDTH(32), .A_WIDTH(8)) dut (
        .clock(clock), .reset_n(reset_n), .bus(bus),
        .ram_address(ram_address), .ram_data(ram_data),
        .ram_wren(ram_wren), .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    // RAM: registered address, unregistered q, word writes.
    logic [31:0] ram_mem [0:255];
    logic [7:0]  ram_aq = '0;
    always @(posedge clock) begin
        ram_aq <= ram_address[7:0];
        if (ram_wren) ram_mem[ram_address[7:0]] <= ram_data;
    end
    assign ram_q = ram_mem[ram_aq];

    // Reference memory: plain byte array, little-endian.
    logic [7:0] ref_mem [0:1023];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a & ~3;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    // Behavioural model: decides error, latency, load result, and the word
    // that a store should leave in the RAM.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err, output logic [31:0] rdata,
                         output int lat, output logic [31:0] wword);
        int size, a, sh;
        logic legal;
        logic [31:0] v;
        logic signed [31:0] s;
        size  = 1 << f3[1:0];
        a     = int'(addr % 1024);
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        rdata = '0;
        wword = '0;
        if (!legal || (addr % size) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        err = 1'b0;
        if (we) begin
            for (int i = 0; i < size; i++) ref_mem[a+i] = 8'((wdata >> (8*i)) & 32'hFF);
            wword = ref_word(a);
            lat   = (size == 4) ? 2 : 4;
        end else begin
            v = '0;
            for (int i = 0; i < size; i++) v = v | (32'(ref_mem[a+i]) << (8*i));
            if (!f3[2] && size < 4) begin
                sh = 32 - 8*size;
                s  = v << sh;
                s  = s >>> sh;
                v  = s;
            end
            rdata = v;
            lat   = 3;
        end
    endtask

    // Issue one request and watch it to completion (bounded).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                          output int lat, output int nwr, output logic [31:0] waddr,
                          output logic [31:0] wdat, output int wcyc);
        int w;
        rdata = '0; err = 1'b0; lat = -1; nwr = 0; waddr = '0; wdat = '0; wcyc = -1;
        @(negedge clock);
        bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = addr; bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        w = 0;
        while (!bus.req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            if (ram_wren) begin
                nwr++; waddr = ram_address; wdat = ram_data; wcyc = k;
            end
            if (bus.resp_valid) begin
                lat = k; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
        int          e_nwr;
        int          e_wcyc;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t tbl [14];

    initial begin
        logic [31:0] rd, wa, wd, m_rd, m_ww, x, held;
        logic        er, m_er;
        int          lat, nwr, wc, m_lat;
        logic        rdy [1:6];
        logic        rv  [1:6];
        logic [31:0] rdv [1:6];
        logic [31:0] r;

        //            we    f3    addr      wdata          rdata          err  lat nwr wcyc wdata
        tbl[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,         1'b0, 2, 1, 1, 32'hDEADBEEF};
        tbl[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF,  1'b0, 3, 0, 0, 32'h0};
        tbl[2]  = '{1'b1, 3'd0, 32'h11, 32'h123456A5, 32'h0,         1'b0, 4, 1, 3, 32'hDEADA5EF};
        tbl[3]  = '{1'b0, 3'd0, 32'h11, 32'h0,        32'hFFFFFFA5,  1'b0, 3, 0, 0, 32'h0};
        tbl[4]  = '{1'b0, 3'd4, 32'h11, 32'h0,        32'h000000A5,  1'b0, 3, 0, 0, 32'h0};
        tbl[5]  = '{1'b1, 3'd1, 32'h12, 32'h00001234, 32'h0,         1'b0, 4, 1, 3, 32'h1234A5EF};
        tbl[6]  = '{1'b0, 3'd1, 32'h12, 32'h0,        32'h00001234,  1'b0, 3, 0, 0, 32'h0};
        tbl[7]  = '{1'b0, 3'd1, 32'h10, 32'h0,        32'hFFFFA5EF,  1'b0, 3, 0, 0, 32'h0};
        tbl[8]  = '{1'b0, 3'd5, 32'h10, 32'h0,        32'h0000A5EF,  1'b0, 3, 0, 0, 32'h0};
        tbl[9]  = '{1'b0, 3'd2, 32'h13, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        tbl[10] = '{1'b1, 3'd1, 32'h11, 32'hFFFF,     32'h0,         1'b1, 1, 0, 0, 32'h0};
        tbl[11] = '{1'b0, 3'd3, 32'h10, 32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
        tbl[12] = '{1'b1, 3'd5, 32'h10, 32'h55,       32'h0,         1'b1, 1, 0, 0, 32'h0};
        tbl[13] = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h1234A5EF,  1'b0, 3, 0, 0, 32'h0};

        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0;

        // Reset values
        #2;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        chk("rst_err", 32'(bus.resp_err), 32'd0);
        chk("rst_ram_out", {31'd0, ram_wren} | ram_address | ram_data, 32'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            do_req(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, er, lat, nwr, wa, wd, wc);
            model(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, m_er, m_rd, m_lat, m_ww);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rdata);
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].e_err));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].e_lat));
            chk($sformatf("tbl%0d_nwr", i), 32'(nwr), 32'(tbl[i].e_nwr));
            if (tbl[i].e_nwr > 0) begin
                chk($sformatf("tbl%0d_wcyc", i), 32'(wc), 32'(tbl[i].e_wcyc));
                chk($sformatf("tbl%0d_waddr", i), wa, tbl[i].addr >> 2);
                chk($sformatf("tbl%0d_wdata", i), wd, tbl[i].e_wdata);
            end
        end

        // Randomized requests against the byte-level model
        for (int n = 0; n < 200; n++) begin
            logic        rwe;
            logic [2:0]  rf3;
            logic [31:0] ra, rw;
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                r  = $urandom;
                ra = ra | (r & 32'hFFFFFC00);
            end
            rw = $urandom;
            do_req(rwe, rf3, ra, rw, rd, er, lat, nwr, wa, wd, wc);
            model(rwe, rf3, ra, rw, m_er, m_rd, m_lat, m_ww);
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(m_er));
            chk($sformatf("rnd%0d_lat", n), 32'(lat), 32'(m_lat));
            chk($sformatf("rnd%0d_rdata", n), rd, m_rd);
            chk($sformatf("rnd%0d_nwr", n), 32'(nwr), (rwe && !m_er) ? 32'd1 : 32'd0);
            if (rwe && !m_er) begin
                chk($sformatf("rnd%0d_wcyc", n), 32'(wc), 32'(m_lat - 1));
                chk($sformatf("rnd%0d_waddr", n), wa, (ra % 1024) >> 2);
                chk($sformatf("rnd%0d_wdata", n), wd, m_ww);
            end
        end

        // Back-to-back: SW then LW with req_valid held high throughout
        x = 32'hC0FFEE11;
        @(negedge clock);
        bus.req_we = 1'b1; bus.req_funct3 = 3'd2; bus.req_addr = 32'h20; bus.req_wdata = x;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_we = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            rdy[k] = bus.req_ready; rv[k] = bus.resp_valid; rdv[k] = bus.resp_rdata;
            if (k == 3) begin
                @(posedge clock);
                #1 bus.req_valid = 1'b0;
            end
        end
        model(1'b1, 3'd2, 32'h20, x, m_er, m_rd, m_lat, m_ww);
        chk("b2b_ready", {26'd0, rdy[1], rdy[2], rdy[3], rdy[4], rdy[5], rdy[6]}, 32'b001000);
        chk("b2b_valid", {26'd0, rv[1], rv[2], rv[3], rv[4], rv[5], rv[6]}, 32'b010001);
        chk("b2b_rdata", rdv[6], x);

        // Reset asserted during WR of an SB
        held = ref_word(32'h30);
        @(negedge clock);
        bus.req_we = 1'b1; bus.req_funct3 = 3'd0; bus.req_addr = 32'h31; bus.req_wdata = 32'h77;
        bus.req_valid = 1'b1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rstwr_in_wr", 32'(ram_wren), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstwr_wren", 32'(ram_wren), 32'd0);
        chk("rstwr_ready", 32'(bus.req_ready), 32'd1);
        chk("rstwr_valid", 32'(bus.resp_valid), 32'd0);
        chk("rstwr_ram_out", ram_address | ram_data, 32'd0);
        chk("rstwr_rdata", bus.resp_rdata, 32'd0);
        er = 1'b0;
        repeat (2) begin
            @(negedge clock);
            er = er | bus.resp_valid;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            er = er | bus.resp_valid;
        end
        chk("rstwr_no_resp", 32'(er), 32'd0);
        do_req(1'b0, 3'd2, 32'h30, 32'h0, rd, er, lat, nwr, wa, wd, wc);
        chk("rstwr_word_kept", rd, held);
        chk("rstwr_word_lat", 32'(lat), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer in the MEM stage of the pipeline. It sits directly upstream of the 32-bit single-port data RAM, which has an M9K-style registered address, unregistered `q` and no byte enables.
- Turns RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into RAM cycles.
- Uses read-modify-write for sub-word stores.
- Sign- or zero-extends load data.
- Flags misaligned or illegal accesses without touching the RAM.

## Interface
Parameters:
- `D_WIDTH`, default 32: data and RAM address bus width.
- `A_WIDTH`, default 8: RAM word-address width (256 words).

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; transfer occurs when `req_valid & req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RISC-V funct3. Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU. Stores: 0 SB, 1 SH, 2 SW.
- `req_addr` in D_WIDTH: byte address.
- `req_wdata` in D_WIDTH: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out D_WIDTH: extended load data; 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal funct3; valid with `resp_valid`.
- `ram_address` out D_WIDTH: word address to the RAM.
- `ram_data` out D_WIDTH: RAM write data.
- `ram_wren` out 1: RAM write enable.
- `ram_q` in D_WIDTH: RAM read data. It is valid the cycle after the address is presented.

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP. Only one request is in flight at a time.
- `req_ready` = 1 only in IDLE. `req_valid` in other states is ignored.
- **Accept (IDLE):** register `req_we`, `req_funct3`, `req_addr`, `req_wdata`.
- **Error check at accept:**
  - Illegal funct3: load 3/6/7, store 3..7.
  - Misaligned: H with `addr[0]=1`; W with `addr[1:0]!=0`.
  - On error: set `resp_err=1` and go to RESP. No RAM access.
- **Routing after accept:**
  - SW goes to WR.
  - All loads and SB/SH go to RD.
- **RD:** drive `ram_address`, `ram_wren=0`. Go to CAP.
- **CAP:** `ram_q` is valid.
  - Load: register the extended result into `resp_rdata` and go to RESP.
    - LB/LH: sign-extend the selected byte/half.
    - LBU/LHU: zero-extend.
    - Byte lane = `addr[1:0]` (bits 8*lane+7..8*lane). Half = `addr[1]` (bits 16*h+15..16*h).
  - SB/SH: register the merge of `ram_q` with `wdata[7:0]`/`wdata[15:0]` into the selected lane. Other lanes are unchanged. Go to WR.
- **WR:** `ram_wren=1`; `ram_data` = merged word (SB/SH) or `req_wdata` (SW). Go to RESP.
- **RESP:** `resp_valid=1` for exactly one cycle. Go to IDLE.
- **RAM address:** `ram_address = {zeros, addr[A_WIDTH+1:2]}`.
  - Driven and held constant in RD, CAP and WR; 0 in IDLE and RESP.
  - Upper address bits are ignored, so addresses wrap modulo 4*2^A_WIDTH bytes.
- `ram_wren` and `ram_data` are decoded from state. `ram_data` = 0 outside WR.
- `resp_rdata` and `resp_err` hold their values until the next response updates them.

## Timing
Accept edge = T. `resp_valid` is high during cycle:
- Error: T+1.
- SW: T+2 (write committed at the edge closing T+1).
- Loads: T+3.
- SB/SH: T+4 (RMW write committed at the edge closing T+3).

Next accept is possible in the cycle after RESP. Peak rate: one SW per 3 cycles.

Reset values: state IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `ram_wren=0`, `ram_address=0`, `ram_data=0`.

Reset asserted mid-operation:
- Outputs drop to their reset values immediately (asynchronous); no response is issued.
- If asserted before the edge closing WR, no RAM write occurs.

Read-during-write never occurs, because RD/CAP and WR are disjoint cycles.

## Test plan
1. Reset, then SW `addr=0x10` `wdata=0xDEADBEEF` → `ram_wren=1` only at T+1 with `ram_address=4`, `ram_data=0xDEADBEEF`; `resp_valid` at T+2, `resp_err=0`, `resp_rdata=0`.
2. LW 0x10 → `ram_address=4` in RD/CAP; `resp_rdata=0xDEADBEEF` with `resp_valid` at T+3; `ram_wren` stays 0.
3. SB 0x11 `wdata=0x123456A5` → write of `0xDEADA5EF` at T+3. Then LB 0x11 → `0xFFFFFFA5`; LBU 0x11 → `0x000000A5`.
4. SH 0x12 `wdata=0x00001234` → word becomes `0x1234A5EF`. LH 0x12 → `0x00001234`; LH 0x10 → `0xFFFFA5EF`; LHU 0x10 → `0x0000A5EF`.
5. LW 0x13, SH 0x11, and load funct3=3 → each gives `resp_valid` at T+1 with `resp_err=1`, `resp_rdata=0`, no RAM access. Word 4 is unchanged on the following LW.
6. Back-to-back requests with `req_valid` held high → second accepted only after RESP. Then `reset_n` low during WR of an SB → `ram_wren` drops at once, no `resp_valid`, `req_ready=1`, and the RAM word is unchanged.
